// File: rtl/dram_arbiter.sv
// Round-robin arbiter giving NUM_CORES cores shared access to a single-port DRAM.
// One access in flight: IDLE grants, ISSUE drives the DRAM, RESP returns the ack.
module dram_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_write_en,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data_in,
    input  logic [DATA_W-1:0]           mem_data_out
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 is_wr_q, is_wr_d;
    logic [NUM_CORES-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    logic [NUM_CORES-1:0] eligible;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     pick_next;
    int                   cand;

    // A core still seeing its ack is masked so it cannot be issued twice.
    assign eligible = core_req & ~ack_q;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_CORES) begin
                cand = cand - NUM_CORES;
            end
            if (!pick_found && eligible[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        pick_next = pick_idx + IDX_W'(1);
        if (int'(pick_idx) == NUM_CORES - 1) begin
            pick_next = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        is_wr_d  = is_wr_q;
        ack_d    = '0;
        rdata_d  = rdata_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                we_d = 1'b0;
                if (pick_found) begin
                    grant_d  = pick_idx;
                    rr_ptr_d = pick_next;
                    is_wr_d  = core_we[pick_idx];
                    we_d     = core_we[pick_idx];
                    addr_d   = core_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_d  = core_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                we_d    = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                ack_d[grant_q] = 1'b1;
                if (!is_wr_q) begin
                    rdata_d = mem_data_out;
                end
                state_d = IDLE;
            end
            default: begin
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            is_wr_q  <= 1'b0;
            ack_q    <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            is_wr_q  <= is_wr_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign core_ack     = ack_q;
    assign core_rdata   = rdata_q;
    assign mem_write_en = we_q;
    assign mem_addr     = addr_q;
    assign mem_data_in  = wdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small behavioural DRAM model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  core_req;
    logic [1:0]  core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [1:0]  core_ack;
    logic [15:0] core_rdata;
    logic        mem_write_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    logic [15:0] ram [256];

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_ack;

    always #5 clk = ~clk;

    dram_arbiter #(
        .NUM_CORES(2),
        .ADDR_W(16),
        .DATA_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .core_req(core_req),
        .core_we(core_we),
        .core_addr(core_addr),
        .core_wdata(core_wdata),
        .core_ack(core_ack),
        .core_rdata(core_rdata),
        .mem_write_en(mem_write_en),
        .mem_addr(mem_addr),
        .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // DRAM: writes when enabled, otherwise registers a read of mem_addr.
    always @(posedge clk) begin
        if (mem_write_en) ram[mem_addr[7:0]] <= mem_data_in;
        else mem_data_out <= ram[mem_addr[7:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0;
        ram[3] = 16'd12;
        mem_data_out = 16'h0;

        // reset held two cycles with both cores requesting writes
        rst = 1'b1;
        core_req = 2'b11;
        core_we = 2'b11;
        core_addr = {16'd40, 16'd3};
        core_wdata = {16'h5555, 16'hAAAA};
        step();
        chk("rst_ack", 32'(core_ack), 32'h0);
        chk("rst_rdata", 32'(core_rdata), 32'h0);
        chk("rst_we", 32'(mem_write_en), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_din", 32'(mem_data_in), 32'h0);
        step();
        chk("rst2_ack", 32'(core_ack), 32'h0);
        chk("rst2_we", 32'(mem_write_en), 32'h0);

        // single read by core0 of addr 3
        rst = 1'b0;
        core_req = 2'b01;
        core_we = 2'b00;
        step();
        chk("rd_addr", 32'(mem_addr), 32'd3);
        chk("rd_we", 32'(mem_write_en), 32'h0);
        chk("rd_ack_t1", 32'(core_ack), 32'h0);
        step();
        chk("rd_ack_t2", 32'(core_ack), 32'h0);
        step();
        chk("rd_ack_t3", 32'(core_ack), 32'h1);
        chk("rd_rdata", 32'(core_rdata), 32'd12);
        core_req = 2'b00;
        step();
        chk("rd_ack_off", 32'(core_ack), 32'h0);
        step();
        step();
        chk("idle_addr_hold", 32'(mem_addr), 32'd3);
        chk("idle_ack", 32'(core_ack), 32'h0);

        // core1 writes BEEF to addr 40; later input changes are ignored
        core_req = 2'b10;
        core_we = 2'b10;
        core_addr = {16'd40, 16'd3};
        core_wdata = {16'hBEEF, 16'h1111};
        step();
        chk("wr_we", 32'(mem_write_en), 32'h1);
        chk("wr_addr", 32'(mem_addr), 32'd40);
        chk("wr_din", 32'(mem_data_in), 32'hBEEF);
        core_addr = {16'd7, 16'd3};
        core_wdata = {16'h0000, 16'h1111};
        step();
        chk("wr_we_off", 32'(mem_write_en), 32'h0);
        chk("wr_addr_kept", 32'(mem_addr), 32'd40);
        chk("wr_ack_t2", 32'(core_ack), 32'h0);
        step();
        chk("wr_ack", 32'(core_ack), 32'h2);
        chk("wr_rdata_kept", 32'(core_rdata), 32'd12);
        core_req = 2'b00;
        core_we = 2'b01;
        step();
        chk("wr_idle_we", 32'(mem_write_en), 32'h0);

        // core1 reads addr 40 back; core0 we is ignored with its req low
        core_req = 2'b10;
        core_we = 2'b01;
        core_addr = {16'd40, 16'd3};
        step();
        chk("rb_addr", 32'(mem_addr), 32'd40);
        chk("rb_we", 32'(mem_write_en), 32'h0);
        core_addr = {16'd3, 16'd3};
        step();
        step();
        chk("rb_ack", 32'(core_ack), 32'h2);
        chk("rb_rdata", 32'(core_rdata), 32'hBEEF);
        core_req = 2'b00;
        step();

        // reset, then both cores request continuously
        rst = 1'b1;
        core_req = 2'b11;
        core_we = 2'b00;
        core_addr = {16'd40, 16'd3};
        step();
        chk("ct_rst_ack", 32'(core_ack), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_ack = 2'b00;
            if (i == 3 || i == 9) exp_ack = 2'b01;
            if (i == 6 || i == 12) exp_ack = 2'b10;
            chk($sformatf("ct_ack_%0d", i), 32'(core_ack), 32'(exp_ack));
            chk($sformatf("ct_we_%0d", i), 32'(mem_write_en), 32'h0);
            if (i == 1) chk("ct_addr_c0", 32'(mem_addr), 32'd3);
            if (i == 4) chk("ct_addr_c1", 32'(mem_addr), 32'd40);
            if (i == 6) chk("ct_rdata_c1", 32'(core_rdata), 32'hBEEF);
        end

        // reset during RESP of core0's read aborts the ack
        step();
        chk("mr_issue_addr", 32'(mem_addr), 32'd3);
        step();
        rst = 1'b1;
        step();
        chk("mr_ack", 32'(core_ack), 32'h0);
        chk("mr_rdata", 32'(core_rdata), 32'h0);
        chk("mr_addr", 32'(mem_addr), 32'h0);
        rst = 1'b0;
        core_req = 2'b00;
        step();
        chk("mr_ack2", 32'(core_ack), 32'h0);
        core_req = 2'b01;
        step();
        chk("mr_regrant_addr", 32'(mem_addr), 32'd3);
        step();
        step();
        chk("mr_regrant_ack", 32'(core_ack), 32'h1);
        chk("mr_regrant_rdata", 32'(core_rdata), 32'd12);
        core_req = 2'b00;
        step();

        // write whose ISSUE coincides with reset lands in DRAM, no ack
        core_req = 2'b10;
        core_we = 2'b10;
        core_addr = {16'd41, 16'd3};
        core_wdata = {16'h1234, 16'h0};
        step();
        chk("aw_we", 32'(mem_write_en), 32'h1);
        rst = 1'b1;
        step();
        chk("aw_we_off", 32'(mem_write_en), 32'h0);
        chk("aw_ack", 32'(core_ack), 32'h0);
        rst = 1'b0;
        core_req = 2'b00;
        step();
        step();
        chk("aw_ack2", 32'(core_ack), 32'h0);
        core_req = 2'b10;
        core_we = 2'b00;
        step();
        step();
        step();
        chk("aw_rb_ack", 32'(core_ack), 32'h2);
        chk("aw_rb_rdata", 32'(core_rdata), 32'h1234);
        core_req = 2'b00;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
